// File: rtl/addr_calcu_arb.sv
// Round-robin arbiter in front of a shared address-count datapath:
// count = address - (BASE - ptr) + b, computed one cycle after accept and held until taken.
module addr_calcu_arb #(
    parameter int                 DATA_W = 8,
    parameter int                 CNT_W  = 16,
    parameter logic [DATA_W-1:0]  BASE   = 8'h80
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] address,
    input  logic [DATA_W-1:0] b,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_ptr,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_ptr,
    output logic              req1_ready,
    output logic              count_valid,
    output logic [CNT_W-1:0]  count,
    output logic              count_id,
    input  logic              count_ready
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nxt;
    logic              last_grant;
    logic              grant0, grant1, accept;
    logic [DATA_W-1:0] addr_p0, b_p0, ptr_p0;
    logic              id_p0;

    // Offset wraps in 8 bits; the final sum wraps in 16 bits with no saturation.
    function automatic logic [CNT_W-1:0] calc_count(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] bb,
                                                    input logic [DATA_W-1:0] p);
        logic [DATA_W-1:0] off;
        off = BASE - p;
        return {{(CNT_W-DATA_W){1'b0}}, a} - {{(CNT_W-DATA_W){1'b0}}, off}
             + {{(CNT_W-DATA_W){1'b0}}, bb};
    endfunction

    // On a tie the requester that did not win last time gets the grant.
    assign grant0 = req0_valid & (~req1_valid | last_grant);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant);
    assign accept = (state == IDLE) & (grant0 | grant1);

    assign count_valid = (state == DONE);

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant0 & ~rst;
                req1_ready = grant1 & ~rst;
                if (grant0 | grant1)
                    state_nxt = CALC;
            end
            CALC: state_nxt = DONE;
            DONE: if (count_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: operand capture on the accept edge
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0 <= address;
            b_p0    <= b;
            ptr_p0  <= grant1 ? req1_ptr : req0_ptr;
            id_p0   <= grant1;
        end
    end

    // Stage p1: registered result, held through DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            count      <= '0;
            count_id   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept)
                last_grant <= grant1;
            if (state == CALC) begin
                count    <= calc_count(addr_p0, b_p0, ptr_p0);
                count_id <= id_p0;
            end
        end
    end

endmodule
